// File: rtl/uart_byte_rx.sv
// 16x-oversampled UART receiver with optional even parity, framing/break handling,
// and a per-frame prescaler latched at the start edge.
module uart_byte_rx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY_EN = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           clk_div,
  input  logic                 Rx_Serial,
  output logic [DATA_BITS-1:0] Rx_Byte,
  output logic                 Rx_Valid,
  output logic                 Rx_Frame_Err,
  output logic                 Rx_Parity_Err,
  output logic                 Rx_Busy
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_e;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_e               state_q;
  logic [1:0]           sync_q, rdy_q;
  logic                 prev_q, brk_hi_q, par_err_q;
  logic [3:0]           div_q, presc_q, cnt_q;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shadow_q, byte_q;
  logic                 valid_q, ferr_q, perr_q;
  logic                 line, tick, mid;

  assign line = sync_q[1];
  assign tick = (presc_q == div_q);
  assign mid  = tick && (cnt_q == 4'd7);

  assign Rx_Byte       = byte_q;
  assign Rx_Valid      = valid_q;
  assign Rx_Frame_Err  = ferr_q;
  assign Rx_Parity_Err = perr_q;
  assign Rx_Busy       = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sync_q    <= 2'b11;
      rdy_q     <= 2'b00;
      prev_q    <= 1'b0;
      brk_hi_q  <= 1'b0;
      par_err_q <= 1'b0;
      div_q     <= '0;
      presc_q   <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shadow_q  <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], Rx_Serial};
      // prev_q only reports high once the synchronizer holds a real post-reset sample,
      // so a line held low through reset cannot fake a start edge.
      rdy_q   <= {rdy_q[0], 1'b1};
      prev_q  <= line & rdy_q[1];
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;

      if (state_q != S_IDLE) begin
        presc_q <= tick ? 4'd0 : presc_q + 4'd1;
        if (tick) cnt_q <= cnt_q + 4'd1;
      end

      case (state_q)
        S_IDLE: if (prev_q && !line) begin
          state_q   <= S_START;
          presc_q   <= '0;
          cnt_q     <= '0;
          div_q     <= clk_div;
          bit_q     <= '0;
          par_err_q <= 1'b0;
        end
        // cnt_q wraps every 16 ticks, so the next mid-sample lands one bit later.
        S_START: if (mid) state_q <= line ? S_IDLE : S_DATA;
        S_DATA: if (mid) begin
          shadow_q <= {line, shadow_q[DATA_BITS-1:1]};
          bit_q    <= bit_q + 3'd1;
          if (bit_q == LAST_BIT) state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
        S_PARITY: if (mid) begin
          par_err_q <= (^shadow_q) ^ line;
          state_q   <= S_STOP;
        end
        S_STOP: if (mid) begin
          if (line) begin
            if (par_err_q) perr_q <= 1'b1;
            else begin
              byte_q  <= shadow_q;
              valid_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end else begin
            ferr_q   <= 1'b1;
            brk_hi_q <= 1'b0;
            state_q  <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (!line) brk_hi_q <= 1'b0;
          else if (tick) begin
            if (brk_hi_q) state_q <= S_IDLE;
            brk_hi_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench: one receiver without parity, one with even parity.
module tb_uart_byte_rx;
  typedef struct {
    bit         id;
    logic [2:0] flags;   // {valid, frame_err, parity_err}
    logic [7:0] data;
  } ev_t;

  localparam logic [2:0] F_VALID = 3'b100;
  localparam logic [2:0] F_FERR  = 3'b010;
  localparam logic [2:0] F_PERR  = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] clk_div = 4'd0;
  logic       rx0 = 1'b1, rxp = 1'b1;
  logic [7:0] byte0, bytep;
  logic       v0, f0, p0, b0, vp, fp, pp, bp;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];
  ev_t mon_e;

  always #5 clk = ~clk;

  uart_byte_rx #(.DATA_BITS(8), .PARITY_EN(0)) u_dut (
    .clk(clk), .rst(rst), .clk_div(clk_div), .Rx_Serial(rx0),
    .Rx_Byte(byte0), .Rx_Valid(v0), .Rx_Frame_Err(f0), .Rx_Parity_Err(p0), .Rx_Busy(b0)
  );

  uart_byte_rx #(.DATA_BITS(8), .PARITY_EN(1)) u_dut_p (
    .clk(clk), .rst(rst), .clk_div(clk_div), .Rx_Serial(rxp),
    .Rx_Byte(bytep), .Rx_Valid(vp), .Rx_Frame_Err(fp), .Rx_Parity_Err(pp), .Rx_Busy(bp)
  );

  // Every output pulse pops the oldest expected event and must match it.
  always @(negedge clk) begin
    if ({v0, f0, p0} != 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected dut=0 flags=%b byte=%h", {v0, f0, p0}, byte0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.id !== 1'b0 || mon_e.flags !== {v0, f0, p0} || mon_e.data !== byte0) begin
          errors++;
          $display("FAIL sb_event dut=0 got flags=%b byte=%h want dut=%0d flags=%b byte=%h",
                   {v0, f0, p0}, byte0, mon_e.id, mon_e.flags, mon_e.data);
        end
      end
    end
    if ({vp, fp, pp} != 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected dut=1 flags=%b byte=%h", {vp, fp, pp}, bytep);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.id !== 1'b1 || mon_e.flags !== {vp, fp, pp} || mon_e.data !== bytep) begin
          errors++;
          $display("FAIL sb_event dut=1 got flags=%b byte=%h want dut=%0d flags=%b byte=%h",
                   {vp, fp, pp}, bytep, mon_e.id, mon_e.flags, mon_e.data);
        end
      end
    end
  end

  task automatic drive(input bit p, input logic v);
    if (p) rxp = v;
    else   rx0 = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit p, input logic [7:0] d, input int pbit,
                            input int stop_bits, input logic stop_v);
    int bt;
    bt = 16 * (int'(clk_div) + 1);
    drive(p, 1'b0); idle(bt);
    for (int i = 0; i < 8; i++) begin
      drive(p, d[i]); idle(bt);
    end
    if (pbit >= 0) begin
      drive(p, pbit[0]); idle(bt);
    end
    drive(p, stop_v); idle(bt * stop_bits);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    idle(4);
    checks += 5;
    if (byte0 !== 8'h00) begin errors++; $display("FAIL rst_byte0 got %h want 00", byte0); end
    if (v0 !== 1'b0) begin errors++; $display("FAIL rst_valid0 got %b want 0", v0); end
    if (f0 !== 1'b0) begin errors++; $display("FAIL rst_ferr0 got %b want 0", f0); end
    if (p0 !== 1'b0) begin errors++; $display("FAIL rst_perr0 got %b want 0", p0); end
    if (b0 !== 1'b0) begin errors++; $display("FAIL rst_busy0 got %b want 0", b0); end
    checks += 2;
    if (bytep !== 8'h00) begin errors++; $display("FAIL rst_bytep got %h want 00", bytep); end
    if ({vp, fp, pp, bp} !== 4'b0000) begin
      errors++; $display("FAIL rst_flagsp got %b want 0000", {vp, fp, pp, bp});
    end
    rst = 1'b1;
    idle(10);
    checks++;
    if ({b0, bp} !== 2'b00) begin errors++; $display("FAIL rst_idle_busy got %b want 00", {b0, bp}); end
  endtask

  task automatic test_good_frame;
    clk_div = 4'd0;
    exp_q.push_back('{id: 1'b0, flags: F_VALID, data: 8'hA5});
    send_frame(1'b0, 8'hA5, -1, 1, 1'b1);
    wait_drain(200);
    idle(16);
    checks += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL good_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    if (b0 !== 1'b0) begin errors++; $display("FAIL good_busy got %b want 0", b0); end
  endtask

  task automatic test_glitch;
    clk_div = 4'd3;
    rx0 = 1'b0;
    idle(20);
    checks++;
    if (b0 !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi got %b want 1", b0); end
    rx0 = 1'b1;
    idle(64);
    checks++;
    if (b0 !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo got %b want 0", b0); end
    exp_q.push_back('{id: 1'b0, flags: F_VALID, data: 8'h3C});
    send_frame(1'b0, 8'h3C, -1, 1, 1'b1);
    wait_drain(400);
    idle(64);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL glitch_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_frame_err;
    clk_div = 4'd0;
    exp_q.push_back('{id: 1'b0, flags: F_FERR, data: 8'h3C});
    send_frame(1'b0, 8'h55, -1, 2, 1'b0);
    checks += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ferr_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    if (b0 !== 1'b1) begin errors++; $display("FAIL ferr_break_busy got %b want 1", b0); end
    rx0 = 1'b1;
    idle(48);
    checks++;
    if (b0 !== 1'b0) begin errors++; $display("FAIL ferr_break_exit got %b want 0", b0); end
    exp_q.push_back('{id: 1'b0, flags: F_VALID, data: 8'h96});
    send_frame(1'b0, 8'h96, -1, 1, 1'b1);
    wait_drain(200);
    idle(16);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ferr_next_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_parity;
    clk_div = 4'd0;
    exp_q.push_back('{id: 1'b1, flags: F_PERR, data: 8'h00});
    send_frame(1'b1, 8'h07, 0, 1, 1'b1);
    idle(32);
    exp_q.push_back('{id: 1'b1, flags: F_VALID, data: 8'h07});
    send_frame(1'b1, 8'h07, 1, 1, 1'b1);
    wait_drain(200);
    idle(16);
    checks += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL parity_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    if (bp !== 1'b0) begin errors++; $display("FAIL parity_busy got %b want 0", bp); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq [3];
    seq = '{8'h00, 8'hFF, 8'h81};
    clk_div = 4'd15;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{id: 1'b0, flags: F_VALID, data: seq[i]});
      send_frame(1'b0, seq[i], -1, 1, 1'b1);
    end
    wait_drain(1000);
    idle(64);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    d = 8'hC3;
    clk_div = 4'd0;
    rx0 = 1'b0; idle(16);
    for (int i = 0; i < 4; i++) begin
      rx0 = d[i]; idle(16);
    end
    rx0 = d[4]; idle(8);
    checks++;
    if (b0 !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre got %b want 1", b0); end
    rst = 1'b0;
    #1;
    checks += 2;
    if (byte0 !== 8'h00) begin errors++; $display("FAIL rstmid_byte got %h want 00", byte0); end
    if ({v0, f0, p0, b0} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_flags got %b want 0000", {v0, f0, p0, b0});
    end
    rx0 = 1'b1;
    idle(20);
    rst = 1'b1;
    idle(40);
    exp_q.push_back('{id: 1'b0, flags: F_VALID, data: 8'h12});
    send_frame(1'b0, 8'h12, -1, 1, 1'b1);
    wait_drain(200);
    idle(16);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_glitch;
    test_frame_err;
    test_parity;
    test_back_to_back;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not complete within budget");
    $fatal(1);
  end
endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame; legal values are 5 to 8.
REQ-002 Parameter PARITY_EN, default 0; when 1, one even-parity bit follows the data bits.
REQ-003 clk  in  1  single clock; all logic runs on the rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 clk_div  in  4  oversample prescale; one oversample tick every clk_div+1 clk cycles.
REQ-006 Rx_Serial  in  1  asynchronous serial line; idles high.
REQ-007 Rx_Byte  out  DATA_BITS  last good received word, LSB = first data bit.
REQ-008 Rx_Valid  out  1  one-cycle pulse: Rx_Byte has just been updated.
REQ-009 Rx_Frame_Err  out  1  one-cycle pulse: stop bit sampled low.
REQ-010 Rx_Parity_Err  out  1  one-cycle pulse: parity mismatch (PARITY_EN=1 only).
REQ-011 Rx_Busy  out  1  high in every state except IDLE.

Function
REQ-012 Rx_Serial SHALL pass through a 2-flop synchronizer; all references to "line" below mean the synchronized value.
REQ-013 Prescaler: counter 0..clk_div; tick fires on the cycle the counter equals the latched divider, then the counter clears; clk_div is latched on start-edge detection, so a change mid-frame has no effect.
REQ-014 Sample counter: 0..15, advancing once per tick, giving 16 ticks per bit; a bit is sampled on the tick where the counter equals 7 (mid-bit).
REQ-015 States: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-016 IDLE->START: line 1->0 edge detected; clears the prescaler and sample counter.
REQ-017 START at mid-sample:
  - line 0 -> DATA, with the counter realigned so that the next mid-sample falls 16 ticks later.
  - line 1 -> IDLE (glitch rejected), with no output pulse.
REQ-018 DATA: shift DATA_BITS samples LSB-first into a shadow register, one per bit mid-sample. After the last bit:
  - go to PARITY if PARITY_EN=1;
  - otherwise go to STOP.
REQ-019 PARITY: compute the XOR of the data bits and the parity sample; a nonzero result sets an internal parity-error flag; then go to STOP.
REQ-020 STOP mid-sample, line 1, no parity error: on the next clk, Rx_Byte <= shadow and Rx_Valid pulses for one cycle; state goes to IDLE.
REQ-021 STOP mid-sample, line 1, parity error: Rx_Parity_Err pulses for one cycle, Rx_Byte is unchanged, Rx_Valid stays 0; state goes to IDLE.
REQ-022 STOP mid-sample, line 0: Rx_Frame_Err pulses for one cycle, Rx_Byte is unchanged, and Rx_Parity_Err is suppressed; state goes to BREAK.
REQ-023 BREAK: hold until the line is 1 for one full tick, then go to IDLE; no start edge is accepted while in BREAK.
REQ-024 Because the state returns to IDLE at the stop mid-sample, a start edge arriving half a bit later SHALL be captured (back-to-back frames with no idle gap).
REQ-025 Rx_Valid, Rx_Frame_Err and Rx_Parity_Err are mutually exclusive, and at most one pulses per frame.
REQ-026 Rx_Byte holds its value until the next good frame; there is no overrun flag.
REQ-027 Latency: Rx_Valid rises 1 clk after the stop-bit mid-sample tick.

Reset
REQ-028 While rst=0:
  - Rx_Byte=0, Rx_Valid=0, Rx_Frame_Err=0, Rx_Parity_Err=0, Rx_Busy=0;
  - state=IDLE, all counters 0, synchronizer flops=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately with no pulse output. After release, the first start edge is not accepted before the line has been observed high.

Verification
REQ-030 Good frame: clk_div=0, PARITY_EN=0, send 0xA5 (16 clk/bit) -> Rx_Byte=0xA5, exactly one Rx_Valid pulse, Rx_Busy low after it.
REQ-031 Glitch: clk_div=3, line low for 20 clk then high -> no pulses, Rx_Busy returns to 0, and a following 0x3C frame is received correctly.
REQ-032 Framing error: send 0x55 with the stop bit held low for 2 bit times -> one Rx_Frame_Err pulse, Rx_Byte keeps its prior value, state is BREAK until the line goes high, then the next frame is received.
REQ-033 Parity: PARITY_EN=1, send 0x07 with parity bit 0 -> one Rx_Parity_Err pulse; send 0x07 with parity bit 1 -> Rx_Valid with Rx_Byte=0x07.
REQ-034 Back-to-back: 0x00, 0xFF, 0x81 sent with zero idle gap at clk_div=15 -> three Rx_Valid pulses carrying the bytes in order.
REQ-035 Reset mid-frame: assert rst during data bit 4 of 0xC3 -> outputs go to 0 at once, no pulse; after release, a fresh 0x12 frame is received correctly.
